// File: rtl/press_sequence_decoder_pkg.sv
// Shared types and default constants for the press sequence decoder.
// Defaults target a 50 MHz system clock.
package press_sequence_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  localparam int DEF_GAP_CYCLES  = 25000000;
  localparam int DEF_MAX_PRESSES = 7;
  localparam int DEF_CNT_W       = 3;
  localparam int DEF_TIMER_W     = 26;

endpackage

// File: rtl/press_sequence_decoder_gap_timer.sv
// Idle-gap timer: counts cycles since the last restart and
// flags the final cycle of the gap window.
module gap_timer
  import press_sequence_decoder_pkg::*;
#(
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMER_W    = DEF_TIMER_W
) (
  input  logic clk_in,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic expire
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(GAP_CYCLES - 1);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/press_sequence_decoder.sv
// Groups debounced press strobes into sequences and reports the
// press count once the idle gap after the last press has elapsed.
module press_sequence_decoder
  import press_sequence_decoder_pkg::*;
#(
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int MAX_PRESSES = DEF_MAX_PRESSES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMER_W     = DEF_TIMER_W
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             press_pulse,
  input  logic             clear,
  output logic             seq_valid,
  output logic [CNT_W-1:0] seq_count,
  output logic             overflow,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PRESSES);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             ovf_flag;
  logic             expire;
  logic             restart;
  logic             enable;

  // Timer only runs while collecting; any press or abort rewinds it.
  assign restart = clear | press_pulse | (state != COLLECT);
  assign enable  = (state == COLLECT);

  gap_timer #(
    .GAP_CYCLES(GAP_CYCLES),
    .TIMER_W   (TIMER_W)
  ) u_gap_timer (
    .clk_in (clk_in),
    .reset  (reset),
    .restart(restart),
    .enable (enable),
    .expire (expire)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      ovf_flag  <= 1'b0;
      seq_count <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      count    <= '0;
      ovf_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (press_pulse) begin
            count    <= ONE;
            ovf_flag <= 1'b0;
            state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (press_pulse) begin
            if (count < MAX_C) begin
              count <= count + ONE;
            end else begin
              ovf_flag <= 1'b1;
            end
          end else if (expire) begin
            state     <= EMIT;
            seq_count <= count;
            overflow  <= ovf_flag;
          end
        end
        EMIT: begin
          if (press_pulse) begin
            count    <= ONE;
            ovf_flag <= 1'b0;
            state    <= COLLECT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign seq_valid = (state == EMIT);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_press_sequence_decoder.sv
// Directed-vector bench for press_sequence_decoder
// (GAP_CYCLES=8, MAX_PRESSES=3, CNT_W=3).
module tb_press_sequence_decoder;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       press_pulse = 1'b0;
  logic       clear = 1'b0;
  logic       seq_valid;
  logic [2:0] seq_count;
  logic       overflow;
  logic       busy;

  int vectors = 0;
  int errors  = 0;

  logic       v_at [0:63];
  logic       b_at [0:63];
  logic       o_at [0:63];
  logic [2:0] c_at [0:63];
  int         vq[$];

  always #5 clk_in = ~clk_in;

  press_sequence_decoder #(
    .GAP_CYCLES (8),
    .MAX_PRESSES(3),
    .CNT_W      (3),
    .TIMER_W    (4)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .press_pulse(press_pulse),
    .clear      (clear),
    .seq_valid  (seq_valid),
    .seq_count  (seq_count),
    .overflow   (overflow),
    .busy       (busy)
  );

  // Edge e samples bit e of each mask; outputs recorded 1 unit after edge e.
  task automatic run_seq(input bit do_rst, input logic [63:0] pm,
                         input logic [63:0] cm, input logic [63:0] rm,
                         input int n);
    vq.delete();
    if (do_rst) begin
      reset = 1'b1;
      press_pulse = 1'b0;
      clear = 1'b0;
      @(posedge clk_in);
      #1;
    end
    for (int e = 1; e <= n; e++) begin
      press_pulse = pm[e];
      clear = cm[e];
      reset = rm[e];
      @(posedge clk_in);
      #1;
      v_at[e] = seq_valid;
      b_at[e] = busy;
      c_at[e] = seq_count;
      o_at[e] = overflow;
      if (seq_valid) vq.push_back(e);
    end
    press_pulse = 1'b0;
    clear = 1'b0;
    reset = 1'b0;
  endtask

  function automatic int strobe(input int k);
    return (vq.size() > k) ? vq[k] : -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    vectors++;
    if (seq_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b exp 0", seq_valid);
    end
    vectors++;
    if (seq_count !== 3'd0) begin
      errors++; $display("FAIL reset_count got %0d exp 0", seq_count);
    end
    vectors++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL reset_overflow got %b exp 0", overflow);
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_single();
    run_seq(1'b1, 64'd1 << 10, '0, '0, 30);
    vectors++;
    if (vq.size() !== 1) begin
      errors++; $display("FAIL single_nstrobe got %0d exp 1", vq.size());
    end
    vectors++;
    if (strobe(0) !== 18) begin
      errors++; $display("FAIL single_edge got %0d exp 18", strobe(0));
    end
    vectors++;
    if (c_at[18] !== 3'd1 || o_at[18] !== 1'b0) begin
      errors++;
      $display("FAIL single_count got %0d/%b exp 1/0", c_at[18], o_at[18]);
    end
    for (int e = 1; e <= 30; e++) begin
      vectors++;
      if (b_at[e] !== ((e >= 10) && (e <= 18))) begin
        errors++; $display("FAIL single_busy edge %0d got %b", e, b_at[e]);
      end
    end
  endtask

  task automatic test_multi();
    run_seq(1'b1, (64'd1 << 10) | (64'd1 << 14) | (64'd1 << 20),
            '0, '0, 35);
    vectors++;
    if (v_at[18] !== 1'b0) begin
      errors++; $display("FAIL multi_early got %b exp 0", v_at[18]);
    end
    vectors++;
    if (vq.size() !== 1 || strobe(0) !== 28) begin
      errors++;
      $display("FAIL multi_edge got n=%0d e=%0d exp 1/28",
               vq.size(), strobe(0));
    end
    vectors++;
    if (c_at[28] !== 3'd3 || o_at[28] !== 1'b0) begin
      errors++;
      $display("FAIL multi_count got %0d/%b exp 3/0", c_at[28], o_at[28]);
    end
  endtask

  task automatic test_clear();
    run_seq(1'b0, (64'd1 << 10) | (64'd1 << 12), 64'd1 << 15, '0, 35);
    vectors++;
    if (vq.size() !== 0) begin
      errors++; $display("FAIL clear_nstrobe got %0d exp 0", vq.size());
    end
    vectors++;
    if (b_at[14] !== 1'b1 || b_at[15] !== 1'b0) begin
      errors++;
      $display("FAIL clear_busy got %b%b exp 10", b_at[14], b_at[15]);
    end
    vectors++;
    if (c_at[35] !== 3'd3 || o_at[35] !== 1'b0) begin
      errors++;
      $display("FAIL clear_hold got %0d/%b exp 3/0", c_at[35], o_at[35]);
    end
  endtask

  task automatic test_saturate();
    logic [63:0] pm;
    pm = '0;
    for (int e = 10; e <= 18; e += 2) pm[e] = 1'b1;
    pm[40] = 1'b1;
    run_seq(1'b1, pm, '0, '0, 55);
    vectors++;
    if (vq.size() !== 2 || strobe(0) !== 26 || strobe(1) !== 48) begin
      errors++;
      $display("FAIL sat_edges got n=%0d %0d,%0d exp 2 26,48",
               vq.size(), strobe(0), strobe(1));
    end
    vectors++;
    if (c_at[26] !== 3'd3 || o_at[26] !== 1'b1) begin
      errors++;
      $display("FAIL sat_count got %0d/%b exp 3/1", c_at[26], o_at[26]);
    end
    vectors++;
    if (c_at[47] !== 3'd3 || o_at[47] !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold got %0d/%b exp 3/1", c_at[47], o_at[47]);
    end
    vectors++;
    if (c_at[48] !== 3'd1 || o_at[48] !== 1'b0) begin
      errors++;
      $display("FAIL sat_next got %0d/%b exp 1/0", c_at[48], o_at[48]);
    end
  endtask

  task automatic test_back_to_back();
    run_seq(1'b1, (64'd1 << 10) | (64'd1 << 17) | (64'd1 << 26),
            '0, '0, 45);
    vectors++;
    if (vq.size() !== 2 || strobe(0) !== 25 || strobe(1) !== 34) begin
      errors++;
      $display("FAIL b2b_edges got n=%0d %0d,%0d exp 2 25,34",
               vq.size(), strobe(0), strobe(1));
    end
    vectors++;
    if (c_at[25] !== 3'd2) begin
      errors++; $display("FAIL b2b_count1 got %0d exp 2", c_at[25]);
    end
    vectors++;
    if (b_at[26] !== 1'b1 || v_at[26] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_collect got busy=%b valid=%b exp 1/0",
               b_at[26], v_at[26]);
    end
    vectors++;
    if (c_at[34] !== 3'd1 || o_at[34] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count2 got %0d/%b exp 1/0", c_at[34], o_at[34]);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] pm;
    pm = (64'd1 << 10) | (64'd1 << 11);
    for (int e = 20; e <= 23; e++) pm[e] = 1'b1;
    run_seq(1'b0, pm, '0, 64'd1 << 14, 40);
    vectors++;
    if (c_at[13] !== 3'd1 || b_at[13] !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre got %0d/%b exp 1/1", c_at[13], b_at[13]);
    end
    vectors++;
    if ({v_at[14], b_at[14], o_at[14], c_at[14]} !== 6'd0) begin
      errors++;
      $display("FAIL rmid_zero got v%b b%b o%b c%0d exp all 0",
               v_at[14], b_at[14], o_at[14], c_at[14]);
    end
    vectors++;
    if (vq.size() !== 1 || strobe(0) !== 31) begin
      errors++;
      $display("FAIL rmid_edge got n=%0d e=%0d exp 1/31",
               vq.size(), strobe(0));
    end
    vectors++;
    if (c_at[31] !== 3'd3 || o_at[31] !== 1'b1) begin
      errors++;
      $display("FAIL rmid_count got %0d/%b exp 3/1", c_at[31], o_at[31]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_clear();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
